// File: rtl/s3g_tx_arbiter.sv
// s3g_tx_arbiter
//
// Shares the single s3g_tx packet transmitter between two reply sources.
// Port A carries command-executor replies and port B carries asynchronous
// event/status reports. Each port owns a one-packet holding slot. Held
// packets are issued to s3g_tx one at a time, with round-robin fairness
// when both slots are occupied. Each issue is paced against tx_busy.
//
// Parameters:
//   DROP_CNT_W        width of the per-port saturating drop counters
//
// Ports (X = a or b):
//   clk               rising-edge clock for all state
//   rst               asynchronous, active-high reset
//   X_packet_wr       one-cycle strobe that captures X_payload_len and X_buf0..15
//   X_payload_len     payload length, passed through unmodified
//   X_buf0..X_buf15   payload bytes
//   X_full            slot X holds a packet that has not been issued yet
//   X_drop_cnt        writes lost to a full slot; saturates at all-ones
//   tx_busy           s3g_tx is busy transmitting
//   tx_packet_wr      one-cycle issue strobe to s3g_tx
//   tx_payload_len    issued payload length, held between issues
//   tx_buf0..tx_buf15 issued payload bytes, held between issues
//   tx_src            source of the last issued packet (0 = A, 1 = B)

module s3g_tx_arbiter #(
  parameter int DROP_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_packet_wr,
  input  logic [7:0]            a_payload_len,
  input  logic [7:0]            a_buf0, a_buf1, a_buf2, a_buf3,
  input  logic [7:0]            a_buf4, a_buf5, a_buf6, a_buf7,
  input  logic [7:0]            a_buf8, a_buf9, a_buf10, a_buf11,
  input  logic [7:0]            a_buf12, a_buf13, a_buf14, a_buf15,
  output logic                  a_full,
  output logic [DROP_CNT_W-1:0] a_drop_cnt,
  input  logic                  b_packet_wr,
  input  logic [7:0]            b_payload_len,
  input  logic [7:0]            b_buf0, b_buf1, b_buf2, b_buf3,
  input  logic [7:0]            b_buf4, b_buf5, b_buf6, b_buf7,
  input  logic [7:0]            b_buf8, b_buf9, b_buf10, b_buf11,
  input  logic [7:0]            b_buf12, b_buf13, b_buf14, b_buf15,
  output logic                  b_full,
  output logic [DROP_CNT_W-1:0] b_drop_cnt,
  input  logic                  tx_busy,
  output logic                  tx_packet_wr,
  output logic [7:0]            tx_payload_len,
  output logic [7:0]            tx_buf0, tx_buf1, tx_buf2, tx_buf3,
  output logic [7:0]            tx_buf4, tx_buf5, tx_buf6, tx_buf7,
  output logic [7:0]            tx_buf8, tx_buf9, tx_buf10, tx_buf11,
  output logic [7:0]            tx_buf12, tx_buf13, tx_buf14, tx_buf15,
  output logic                  tx_src
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    BUSY
  } state_t;

  localparam logic [DROP_CNT_W-1:0] DROP_MAX = {DROP_CNT_W{1'b1}};

  state_t          state;
  state_t          state_nxt;
  logic            last_grant;
  logic            grant;
  logic            grant_a;
  logic            grant_b;

  logic [15:0][7:0] a_in;
  logic [15:0][7:0] b_in;
  logic [15:0][7:0] a_slot;
  logic [15:0][7:0] b_slot;
  logic [15:0][7:0] tx_bytes;
  logic [7:0]       a_len;
  logic [7:0]       b_len;

  // Byte 0 lands in the lowest lane so slot[i] lines up with buf<i>.
  assign a_in = {a_buf15, a_buf14, a_buf13, a_buf12, a_buf11, a_buf10, a_buf9, a_buf8,
                 a_buf7,  a_buf6,  a_buf5,  a_buf4,  a_buf3,  a_buf2,  a_buf1, a_buf0};
  assign b_in = {b_buf15, b_buf14, b_buf13, b_buf12, b_buf11, b_buf10, b_buf9, b_buf8,
                 b_buf7,  b_buf6,  b_buf5,  b_buf4,  b_buf3,  b_buf2,  b_buf1, b_buf0};
  assign {tx_buf15, tx_buf14, tx_buf13, tx_buf12, tx_buf11, tx_buf10, tx_buf9, tx_buf8,
          tx_buf7,  tx_buf6,  tx_buf5,  tx_buf4,  tx_buf3,  tx_buf2,  tx_buf1, tx_buf0} = tx_bytes;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A grant happens only from IDLE with s3g_tx idle. When both slots are
  // full, the port that did not win last time is served.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    grant_b   = 1'b0;
    case (state)
      IDLE: begin
        if ((a_full || b_full) && !tx_busy) begin
          grant     = 1'b1;
          grant_b   = b_full && (!a_full || !last_grant);
          state_nxt = SETTLE;
        end
      end
      // s3g_tx raises tx_busy one cycle after the strobe, so skip that cycle.
      SETTLE:  state_nxt = BUSY;
      BUSY:    if (!tx_busy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign grant_a = grant && !grant_b;

  // Slot A: a write is accepted when the slot is empty or is being drained
  // this very cycle. Otherwise it is dropped and counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_full     <= 1'b0;
      a_len      <= '0;
      a_slot     <= '0;
      a_drop_cnt <= '0;
    end else if (a_packet_wr && (!a_full || grant_a)) begin
      a_full <= 1'b1;
      a_len  <= a_payload_len;
      a_slot <= a_in;
    end else begin
      if (grant_a) a_full <= 1'b0;
      if (a_packet_wr && a_drop_cnt != DROP_MAX) a_drop_cnt <= a_drop_cnt + 1'b1;
    end
  end

  // Slot B mirrors slot A.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_full     <= 1'b0;
      b_len      <= '0;
      b_slot     <= '0;
      b_drop_cnt <= '0;
    end else if (b_packet_wr && (!b_full || grant_b)) begin
      b_full <= 1'b1;
      b_len  <= b_payload_len;
      b_slot <= b_in;
    end else begin
      if (grant_b) b_full <= 1'b0;
      if (b_packet_wr && b_drop_cnt != DROP_MAX) b_drop_cnt <= b_drop_cnt + 1'b1;
    end
  end

  // Issue register. Payload outputs keep the last issued packet between
  // grants. last_grant starts at B so that A wins the first contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_packet_wr   <= 1'b0;
      tx_payload_len <= '0;
      tx_bytes       <= '0;
      tx_src         <= 1'b0;
      last_grant     <= 1'b1;
    end else begin
      tx_packet_wr <= grant;
      if (grant) begin
        tx_payload_len <= grant_b ? b_len : a_len;
        tx_bytes       <= grant_b ? b_slot : a_slot;
        tx_src         <= grant_b;
        last_grant     <= grant_b;
      end
    end
  end

endmodule
